// File: rtl/maze_pkg.sv
// Shared types and constants for the maze store that feeds the rat solver.
`timescale 1ns/1ps
package maze_pkg;

   localparam int DIM     = 16;
   localparam int COORD_W = $clog2(DIM);

   localparam logic CELL_FREE = 1'b0;
   localparam logic CELL_WALL = 1'b1;

   typedef enum logic {
      LOAD  = 1'b0,
      READY = 1'b1
   } maze_state_t;

   typedef logic [DIM-1:0] maze_row_t;

   // One-hot row select for the bulk-load write enables.
   function automatic maze_row_t row_onehot(input logic [COORD_W-1:0] idx);
      maze_row_t v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/maze_loader.sv
// Row-load sequencer: tracks which row the valid/ready port fills next and
// reports when the whole maze is present.
`timescale 1ns/1ps
module maze_loader
   import maze_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        load_start,
   input  logic        load_valid,
   output maze_state_t state,
   output logic        load_ready,
   output logic        load_done,
   output maze_row_t   row_we,
   output logic        clear
);

   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(DIM - 1);

   logic [COORD_W-1:0] row_cnt;
   logic               accept;

   assign accept = load_valid & load_ready;

   // Row write strobes; a restart on the same edge discards the offered row.
   always_comb begin
      clear  = load_start;
      row_we = '0;
      if (accept && !load_start) begin
         row_we = row_onehot(row_cnt);
      end else begin
         row_we = '0;
      end
   end

   // Load FSM with registered handshake outputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= LOAD;
         row_cnt    <= '0;
         load_ready <= 1'b1;
         load_done  <= 1'b0;
      end else if (load_start) begin
         state      <= LOAD;
         row_cnt    <= '0;
         load_ready <= 1'b1;
         load_done  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  if (row_cnt == LAST_ROW) begin
                     state      <= READY;
                     load_ready <= 1'b0;
                     load_done  <= 1'b1;
                  end else begin
                     row_cnt <= row_cnt + 1'b1;
                  end
               end
            end
            READY: begin
               load_ready <= 1'b0;
               load_done  <= 1'b1;
            end
            default: begin
               state      <= LOAD;
               row_cnt    <= '0;
               load_ready <= 1'b1;
               load_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/maze_ram.sv
// Maze storage for the rat solver: pristine and working 16x16 bit arrays,
// solver read/write port and one-cycle restore of the working copy.
`timescale 1ns/1ps
module maze_ram
   import maze_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [DIM-1:0]     load_row,
   output logic               load_ready,
   output logic               load_done,
   input  logic               restore,
   input  logic               RD,
   input  logic               WR,
   input  logic               Din,
   input  logic [COORD_W-1:0] X,
   input  logic [COORD_W-1:0] Y,
   output logic               Dout,
   output logic               access_err
);

   maze_state_t state;
   maze_row_t   row_we;
   logic        clear;
   logic        in_ready;

   maze_row_t pristine [DIM];
   maze_row_t working  [DIM];

   assign in_ready = (state == READY);

   maze_loader u_loader (
      .CLK        (CLK),
      .RST        (RST),
      .load_start (load_start),
      .load_valid (load_valid),
      .state      (state),
      .load_ready (load_ready),
      .load_done  (load_done),
      .row_we     (row_we),
      .clear      (clear)
   );

   // Pristine copy: written only by the bulk-load port.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int r = 0; r < DIM; r++) begin
            pristine[r] <= '0;
         end
      end else begin
         for (int r = 0; r < DIM; r++) begin
            if (clear) begin
               pristine[r] <= '0;
            end else if (row_we[r]) begin
               pristine[r] <= load_row;
            end
         end
      end
   end

   // Working copy: bulk load, then restore (which beats a solver write), then solver write.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int r = 0; r < DIM; r++) begin
            working[r] <= '0;
         end
      end else begin
         for (int r = 0; r < DIM; r++) begin
            if (clear) begin
               working[r] <= '0;
            end else if (row_we[r]) begin
               working[r] <= load_row;
            end else if (in_ready && restore) begin
               working[r] <= pristine[r];
            end else if (in_ready && WR && (Y == COORD_W'(r))) begin
               working[r][X] <= Din;
            end
         end
      end
   end

   // Solver read; during loading every cell looks like a wall.
   always_comb begin
      Dout = CELL_FREE;
      if (!RD) begin
         Dout = CELL_FREE;
      end else if (in_ready) begin
         Dout = working[Y][X];
      end else begin
         Dout = CELL_WALL;
      end
   end

   // Flag solver strobes that arrive before the maze is complete.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         access_err <= 1'b0;
      end else begin
         access_err <= (RD | WR) & ~in_ready;
      end
   end

endmodule

// File: tb/tb_maze_ram.sv
// Directed bench for maze_ram: load, read, write, restore, reload and reset-mid-load.
`timescale 1ns/1ps
module tb_maze_ram;
   import maze_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        load_start;
   logic        load_valid;
   logic [15:0] load_row;
   logic        load_ready;
   logic        load_done;
   logic        restore;
   logic        RD;
   logic        WR;
   logic        Din;
   logic [3:0]  X;
   logic [3:0]  Y;
   logic        Dout;
   logic        access_err;

   int n_cmp = 0;
   int n_err = 0;
   bit err_seen;

   always #5 CLK = ~CLK;

   maze_ram dut (
      .CLK        (CLK),
      .RST        (RST),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_row   (load_row),
      .load_ready (load_ready),
      .load_done  (load_done),
      .restore    (restore),
      .RD         (RD),
      .WR         (WR),
      .Din        (Din),
      .X          (X),
      .Y          (Y),
      .Dout       (Dout),
      .access_err (access_err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Row 3 is the 16'h0010 row; other rows put the row index in the top nibble
   // and its complement in the bottom nibble. alt inverts the whole maze.
   function automatic logic [15:0] pat(input int r, input bit alt);
      logic [3:0]  r4;
      logic [15:0] v;
      r4 = r[3:0];
      v  = {r4, 8'h00, ~r4};
      if (r == 3) v = 16'h0010;
      if (alt) v = ~v;
      return v;
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_rows(input int first, input int cnt, input bit alt);
      for (int i = 0; i < cnt; i++) begin
         load_row   = pat(first + i, alt);
         load_valid = 1'b1;
         #1;
         check_val($sformatf("ready_row%0d", first + i), 32'(load_ready), 32'd1);
         step();
         if (access_err) err_seen = 1'b1;
      end
      load_valid = 1'b0;
   endtask

   task automatic scan(input bit alt, input string tag);
      int          errs;
      logic [15:0] row;
      errs = 0;
      RD   = 1'b1;
      for (int y = 0; y < 16; y++) begin
         row = pat(y, alt);
         for (int x = 0; x < 16; x++) begin
            X = x[3:0];
            Y = y[3:0];
            #1;
            if (Dout !== row[x]) errs++;
            step();
         end
      end
      RD = 1'b0;
      check_val(tag, 32'(errs), 32'd0);
   endtask

   initial begin
      logic [15:0] acc_w;
      logic [15:0] acc_p;
      RST = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_row = 16'h0000;
      restore = 1'b0; RD = 1'b0; WR = 1'b0; Din = 1'b0; X = 4'd0; Y = 4'd0;
      err_seen = 1'b0;
      #12;
      check_val("rst_ready", 32'(load_ready), 32'd1);
      check_val("rst_done", 32'(load_done), 32'd0);
      check_val("rst_err", 32'(access_err), 32'd0);
      check_val("rst_dout", 32'(Dout), 32'd0);
      @(negedge CLK) RST = 1'b1;
      step();

      // 1: full load
      load_rows(0, 15, 1'b0);
      check_val("done_after15", 32'(load_done), 32'd0);
      load_rows(15, 1, 1'b0);
      check_val("done_after16", 32'(load_done), 32'd1);
      check_val("ready_after16", 32'(load_ready), 32'd0);
      check_val("no_err_load", 32'(err_seen), 32'd0);

      // 2: directed reads of row 3
      RD = 1'b1; X = 4'd4; Y = 4'd3; #1;
      check_val("rd_x4y3", 32'(Dout), 32'd1);
      X = 4'd5; #1;
      check_val("rd_x5y3", 32'(Dout), 32'd0);
      RD = 1'b0; #1;
      check_val("rd_off", 32'(Dout), 32'd0);
      step();
      scan(1'b0, "scan_load");

      // 3: write with same-cycle read
      X = 4'd2; Y = 4'd7; RD = 1'b1; WR = 1'b1; Din = 1'b1; #1;
      check_val("wr_same_cycle", 32'(Dout), 32'd0);
      step();
      WR = 1'b0; #1;
      check_val("wr_next_cycle", 32'(Dout), 32'd1);
      check_val("wr_no_err", 32'(access_err), 32'd0);
      RD = 1'b0;

      // 4: restore, then restore beating a write
      X = 4'd12; Y = 4'd1; WR = 1'b1; Din = 1'b0;
      step();
      WR = 1'b0; RD = 1'b1; #1;
      check_val("wr_clear_bit", 32'(Dout), 32'd0);
      RD = 1'b0; restore = 1'b1;
      step();
      restore = 1'b0;
      scan(1'b0, "scan_restore");
      X = 4'd2; Y = 4'd7; WR = 1'b1; Din = 1'b1; restore = 1'b1;
      step();
      WR = 1'b0; restore = 1'b0; RD = 1'b1; #1;
      check_val("restore_beats_wr", 32'(Dout), 32'd0);
      RD = 1'b0;
      step();

      // 5: reload, access during LOAD
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      check_val("start_done", 32'(load_done), 32'd0);
      check_val("start_ready", 32'(load_ready), 32'd1);
      load_rows(0, 5, 1'b1);
      RD = 1'b1; WR = 1'b1; Din = 1'b1; X = 4'd0; Y = 4'd0; #1;
      check_val("rd_in_load", 32'(Dout), 32'd1);
      check_val("err_before", 32'(access_err), 32'd0);
      step();
      RD = 1'b0; WR = 1'b0;
      check_val("err_pulse", 32'(access_err), 32'd1);
      step();
      check_val("err_one_cycle", 32'(access_err), 32'd0);
      load_rows(5, 11, 1'b1);
      check_val("reload_done", 32'(load_done), 32'd1);
      scan(1'b1, "scan_reload");

      // 6: reset mid-load
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      load_rows(0, 8, 1'b0);
      @(negedge CLK) RST = 1'b0;
      #1;
      acc_w = 16'h0000;
      acc_p = 16'h0000;
      for (int r = 0; r < 16; r++) begin
         acc_w = acc_w | dut.working[r];
         acc_p = acc_p | dut.pristine[r];
      end
      check_val("rst_row_cnt", 32'(dut.u_loader.row_cnt), 32'd0);
      check_val("rst_working", 32'(acc_w), 32'd0);
      check_val("rst_pristine", 32'(acc_p), 32'd0);
      check_val("rst_mid_ready", 32'(load_ready), 32'd1);
      check_val("rst_mid_done", 32'(load_done), 32'd0);
      @(negedge CLK) RST = 1'b1;
      step();
      load_rows(0, 15, 1'b1);
      check_val("rl_done_after15", 32'(load_done), 32'd0);
      load_rows(15, 1, 1'b1);
      check_val("rl_done_after16", 32'(load_done), 32'd1);
      scan(1'b1, "scan_after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
